// File: rtl/pm_boot_ctrl.sv
// Program-memory boot controller: muxes the single PM port between loader writes (1 cycle after accept) and sequencer fetch.
// Loader sees ld_ready only while loading; the CPU stays in sync reset until the image is written and word 0 is presented.
module pm_boot_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ps_pm_addr,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_data,
  output logic              pm_we,
  output logic              cpu_sync_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HALT,
    S_LOAD,
    S_REL1,
    S_REL2,
    S_RUN,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_pm_data;
  logic              r_pm_we;
  logic              r_drain;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_words_loaded;

  logic              w_accept;
  logic              w_ptr_full;
  logic              w_enter_load;
  logic [ADDR_W-1:0] w_pm_addr;

  // An overflow byte drains for one LOAD cycle with ld_ready low, so its write keeps the loader address.
  assign ld_ready     = (r_state == S_LOAD) && !r_drain;
  assign w_accept     = ld_valid && ld_ready;
  assign w_ptr_full   = (r_wr_ptr == {ADDR_W{1'b1}});
  assign w_enter_load = load_req &&
                        ((r_state == S_HALT) || (r_state == S_RUN) || (r_state == S_ERR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_HALT;
      r_wr_ptr       <= '0;
      r_wr_addr      <= '0;
      r_pm_data      <= '0;
      r_pm_we        <= 1'b0;
      r_drain        <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      r_done  <= 1'b0;
      r_pm_we <= 1'b0;
      case (r_state)
        S_HALT: begin
          if (load_req) begin
            r_state <= S_LOAD;
          end else if (run_req) begin
            r_state <= S_REL2;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_wr_addr      <= r_wr_ptr;
            r_pm_data      <= ld_data;
            r_pm_we        <= 1'b1;
            r_wr_ptr       <= r_wr_ptr + 1'b1;
            r_words_loaded <= r_words_loaded + 1'b1;
            if (ld_last) begin
              r_state <= S_REL1;
            end else if (w_ptr_full) begin
              r_drain <= 1'b1;
            end
          end else if (r_drain) begin
            r_drain <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_REL1: r_state <= S_REL2;
        S_REL2: begin
          r_state <= S_RUN;
          r_done  <= 1'b1;
        end
        S_RUN, S_ERR: begin
          if (load_req) begin
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_HALT;
      endcase

      if (w_enter_load) begin
        r_wr_ptr       <= '0;
        r_words_loaded <= '0;
        r_drain        <= 1'b0;
        r_err          <= 1'b0;
      end
    end
  end

  always_comb begin
    w_pm_addr = '0;
    case (r_state)
      S_LOAD, S_REL1: w_pm_addr = r_wr_addr;
      S_REL2, S_RUN:  w_pm_addr = ps_pm_addr;
      default:        w_pm_addr = '0;
    endcase
  end

  assign pm_addr        = w_pm_addr;
  assign pm_data        = r_pm_data;
  assign pm_we          = r_pm_we && ((r_state == S_LOAD) || (r_state == S_REL1));
  assign cpu_sync_reset = (r_state != S_RUN);
  assign busy           = (r_state == S_LOAD) || (r_state == S_REL1) || (r_state == S_REL2);
  assign done           = r_done;
  assign err            = r_err;
  assign words_loaded   = r_words_loaded;

endmodule

// File: tb/tb_pm_boot_ctrl.sv
// Bench for pm_boot_ctrl: randomized loads/runs; expected writes and done cycles are queued at issue and popped by a monitor.
module tb_pm_boot_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic              load_req, run_req, ld_valid, ld_last;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [ADDR_W-1:0] ps_pm_addr;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_data;
  logic              pm_we, cpu_sync_reset, busy, done, err;
  logic [ADDR_W:0]   words_loaded;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  img[DEPTH];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  pm_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .run_req(run_req),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ps_pm_addr(ps_pm_addr), .pm_addr(pm_addr), .pm_data(pm_data), .pm_we(pm_we),
    .cpu_sync_reset(cpu_sync_reset), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_t w;
    if (pm_we !== 1'b0) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", pm_addr, pm_data);
      end else begin
        w = wq.pop_front();
        chk("write_addr", pm_addr, w.addr);
        chk("write_data", pm_data, w.data);
      end
    end
    if (done !== 1'b0) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: cycle %0d, none expected", cyc);
      end else begin
        chk("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_img(input int n);
    for (int i = 0; i < n; i++) img[i] = $urandom_range(0, 255);
  endtask

  task automatic load_image(input int n, input bit overflow, input int gap_mode, input bit hold_req);
    int sent = 0;
    int k    = 0;
    bit vld;
    load_req = 1'b1;
    run_req  = 1'($urandom_range(0, 1));
    tick();
    run_req  = 1'b0;
    load_req = hold_req;
    while (sent < n) begin
      case (gap_mode)
        1:       vld = ((k % 2) == 0);
        2:       vld = ($urandom_range(0, 3) != 0);
        default: vld = 1'b1;
      endcase
      k++;
      ld_valid   = vld;
      ld_data    = DATA_W'(img[sent]);
      ld_last    = vld ? (!overflow && (sent == n - 1)) : 1'($urandom_range(0, 1));
      ps_pm_addr = ADDR_W'($urandom);
      #2;
      chk("load_ld_ready", ld_ready, 1);
      chk("load_words_loaded", words_loaded, sent);
      if (k == 1) chk("load_sync_reset", cpu_sync_reset, 1);
      if (vld) begin
        wq.push_back('{sent, img[sent]});
        if (ld_last) dq.push_back(cyc + 3);
        sent++;
      end
      tick();
    end
    load_req   = 1'b0;
    ld_valid   = 1'b1;
    ld_last    = 1'b1;
    ld_data    = DATA_W'($urandom);
    ps_pm_addr = ADDR_W'($urandom);
    #2;
    chk("post_busy", busy, 1);
    chk("post_sync_reset", cpu_sync_reset, 1);
    tick();
    if (overflow) begin
      ps_pm_addr = ADDR_W'($urandom);
      #2;
      chk("ovf_err", err, 1);
      chk("ovf_sync_reset", cpu_sync_reset, 1);
      chk("ovf_busy", busy, 0);
      chk("ovf_ld_ready", ld_ready, 0);
      chk("ovf_pm_addr", pm_addr, 0);
      chk("ovf_words_loaded", words_loaded, DEPTH);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      #2;
      chk("err_sticky", err, 1);
      chk("err_held", cpu_sync_reset, 1);
      ld_valid = 1'b0;
      tick();
    end else begin
      ps_pm_addr = ADDR_W'($urandom);
      #2;
      chk("rel2_pm_addr", pm_addr, ps_pm_addr);
      chk("rel2_busy", busy, 1);
      chk("rel2_sync_reset", cpu_sync_reset, 1);
      chk("rel2_ld_ready", ld_ready, 0);
      tick();
      ld_valid = 1'b0;
      #2;
      chk("run_sync_reset", cpu_sync_reset, 0);
      chk("run_busy", busy, 0);
      chk("run_words_loaded", words_loaded, n);
      tick();
    end
  endtask

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      ps_pm_addr = ADDR_W'($urandom);
      run_req    = 1'($urandom_range(0, 1));
      ld_valid   = 1'($urandom_range(0, 1));
      ld_last    = 1'($urandom_range(0, 1));
      #2;
      chk("run_pm_addr", pm_addr, ps_pm_addr);
      chk("run_pm_we", pm_we, 0);
      chk("run_held_low", cpu_sync_reset, 0);
      chk("run_ld_ready", ld_ready, 0);
      tick();
    end
    run_req  = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    chk("rst_pm_we", pm_we, 0);
    chk("rst_pm_data", pm_data, 0);
    chk("rst_words_loaded", words_loaded, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_sync_reset", cpu_sync_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pm_addr", pm_addr, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_from_halt();
    run_req = 1'b1;
    dq.push_back(cyc + 2);
    tick();
    run_req    = 1'b0;
    ps_pm_addr = ADDR_W'($urandom);
    #2;
    chk("rr_rel2_busy", busy, 1);
    chk("rr_rel2_pm_addr", pm_addr, ps_pm_addr);
    chk("rr_rel2_sync_reset", cpu_sync_reset, 1);
    tick();
    #2;
    chk("rr_run_sync_reset", cpu_sync_reset, 0);
    chk("rr_run_busy", busy, 0);
    tick();
  endtask

  initial begin
    load_req   = 1'b0;
    run_req    = 1'b0;
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    ld_data    = '0;
    ps_pm_addr = '0;
    tick();
    apply_reset();

    // Loader traffic in HALT must be ignored.
    for (int i = 0; i < 3; i++) begin
      ld_valid   = 1'b1;
      ld_last    = 1'($urandom_range(0, 1));
      ld_data    = DATA_W'($urandom);
      ps_pm_addr = ADDR_W'($urandom);
      #2;
      chk("halt_ld_ready", ld_ready, 0);
      chk("halt_pm_addr", pm_addr, 0);
      chk("halt_sync_reset", cpu_sync_reset, 1);
      tick();
    end
    ld_valid = 1'b0;

    img[0] = 'hA1; img[1] = 'hB2; img[2] = 'hC3; img[3] = 'hD4;
    load_image(4, 1'b0, 0, 1'b0);
    run_cycles(6);

    fill_img(3);
    load_image(3, 1'b0, 1, 1'b0);
    run_cycles(4);

    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 40);
      fill_img(n);
      load_image(n, 1'b0, 2, 1'($urandom_range(0, 1)));
      run_cycles($urandom_range(1, 5));
    end

    fill_img(DEPTH);
    load_image(DEPTH, 1'b1, 0, 1'b0);
    fill_img(5);
    load_image(5, 1'b0, 2, 1'b1);
    run_cycles(3);

    apply_reset();
    run_from_halt();
    run_cycles(4);

    // Reset lands in the middle of a load after two bytes.
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_last  = 1'b0;
      ld_data  = DATA_W'($urandom);
      wq.push_back('{i, int'(ld_data)});
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = DATA_W'($urandom);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_pm_we", pm_we, 0);
    chk("midrst_words_loaded", words_loaded, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ld_ready", ld_ready, 0);
    chk("midrst_sync_reset", cpu_sync_reset, 1);
    tick();
    tick();
    reset    = 1'b0;
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("after_rst_busy", busy, 0);
      chk("after_rst_pm_we", pm_we, 0);
      tick();
    end

    chk("writes_drained", wq.size(), 0);
    chk("dones_drained", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
